booth_seq_mul: RTL
==================

# booth_seq_mul

Iterative signed radix-4 Booth multiplier. It produces one Booth partial product per cycle and accumulates it into a 2N-bit register through a carry-select adder. It sits directly upstream of the carry-select adder blocks in the booth multiplier datapath. It generates the operand and carry-in (`sel`) that each CS block consumes, and it owns the control and handshake around them.

## Interface
Parameters:
- N, default 16: operand width in bits. Must be even and ≥ 4.
- SIZE_CS, default 4: width of each carry-select block in the 2N-bit accumulator adder. Must divide 2N.

Ports:
- clk, input, 1: single clock. All state updates on the rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- in_valid, input, 1: A and B are valid this cycle.
- in_ready, output, 1: block accepts operands. High only in IDLE.
- A, input, N: multiplicand, two's complement.
- B, input, N: multiplier, two's complement, Booth-recoded.
- out_valid, output, 1: P holds a finished product.
- out_ready, input, 1: consumer takes P.
- P, output, 2N: signed product A*B.
- busy, output, 1: high in RUN or DONE.

## Operation
- States:
  - IDLE: in_ready=1. On in_valid & in_ready, register A sign-extended to 2N bits and B with an appended b[-1]=0. Clear the accumulator and set the digit counter i=0. Go to RUN.
  - RUN: each cycle, recode triplet {b[2i+1], b[2i], b[2i-1]} into digit d ∈ {-2,-1,0,+1,+2}: 000/111→0, 001/010→+1, 011→+2, 100→-2, 101/110→-1.
    - Partial product: |d|·A (A or A<<1), shifted left by 2i, truncated to 2N bits.
    - Negative d: the adder operand is the bitwise inverse of the shifted magnitude, and carry-in is 1 (two's-complement negate). Otherwise carry-in is 0.
    - d=0: operand 0, carry-in 0.
    - acc ← acc + operand + cin, modulo 2^2N. i ← i+1.
    - After digit i=N/2-1, load P ← final acc and go to DONE.
  - DONE: out_valid=1 and P is held stable. On out_ready=1, go to IDLE and drop out_valid the next cycle.
- Addition is modulo 2^2N with no overflow flag. All N-bit signed products fit exactly.
- Carry chain: 2N/SIZE_CS carry-select blocks, rippled. Block 0 `sel` is the Booth carry-in. Block k `sel` is the carry-out of block k-1. The final carry-out is discarded.
- Inputs are not sampled outside IDLE. in_valid during RUN or DONE is ignored; the producer must hold it.
- No new operands are accepted in the same cycle that DONE completes. in_ready rises only once the state is IDLE.

## Timing
- Reset values (asserted at any time, independent of clk): state=IDLE, in_ready=1, out_valid=0, busy=0, P=0, accumulator=0, i=0.
- Reset during RUN or DONE aborts the operation, and the result is lost. After rst_n deasserts, the first accepted operand pair computes correctly.
- Latency: acceptance at edge E0. RUN spans edges E1..E(N/2). out_valid is high from edge E(N/2), which is 8 cycles for N=16.
- Throughput: at most one product per N/2+2 cycles when out_ready is held high.
- Back-pressure: out_valid and P stay constant for any number of cycles with out_ready=0.
- in_ready, out_valid and busy are decoded from registered state only. They have no combinational path from in_valid or out_ready.
- Critical path: operand mux → 2N-bit carry-select adder → accumulator.

## Test plan
- Small product, N=16: A=3, B=5 → out_valid 8 cycles after acceptance, P=0x0000000F. in_ready=0 while busy.
- Sign corner cases: A=-32768, B=-32768 → P=0x40000000. A=32767, B=-32768 → P=0xC0008000. A=-1, B=1 → P=0xFFFFFFFF.
- Back-pressure: A=-7, B=9, out_ready held 0 for 20 cycles → P=0xFFFFFFC1 stable, out_valid=1 throughout. Then out_ready=1 for one cycle → IDLE, in_ready=1 next cycle.
- Ignored input: in_valid with A=1, B=1 pulsed during RUN of A=100, B=-3 → P=0xFFFFFED4. The pulsed pair is not consumed.
- Reset mid-RUN: assert rst_n=0 asynchronously at digit i=3 → outputs return immediately to reset values. After release, A=12345, B=-2 → P=0xFFFF9F8E.
- Random: 10k random signed pairs with back-to-back acceptance and random out_ready → every P equals the signed A*B reference model. Handshake counts match.

Source files
------------

// File: rtl/booth_seq_mul_if.sv
// Operand/result handshake bundle for the sequential radix-4 Booth multiplier.
// The producer/consumer side takes the master modport, the multiplier takes the slave modport.
interface booth_seq_mul_if #(
    parameter int N = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   A;
    logic [N-1:0]   B;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] P;
    logic           busy;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, P, busy
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, P, busy
    );
endinterface

// File: rtl/booth_seq_mul.sv
// Iterative signed radix-4 Booth multiplier: one partial product per cycle, accumulated
// into a 2N-bit register through a rippled chain of carry-select blocks.
module booth_seq_mul #(
    parameter int N       = 16,
    parameter int SIZE_CS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    booth_seq_mul_if.slave     mul_if
);
    localparam int W  = 2 * N;
    localparam int NB = W / SIZE_CS;
    localparam int CW = (N / 2 > 1) ? $clog2(N / 2) : 1;
    localparam logic [CW-1:0] LAST = CW'(N / 2 - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [N:0]      b_q;
    logic [W-1:0]    acc_q;
    logic [W-1:0]    p_q;
    logic [CW-1:0]   i_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic            busy_q;

    logic [W-1:0]    operand;
    logic            neg;
    logic [W-1:0]    sum;
    logic [NB-1:0]   carry;

    // Multiplicand and multiplier are shifted by two each digit, so the recoded triplet is always b_q[2:0].
    always_comb begin
        operand = '0;
        neg     = 1'b0;
        case (b_q[2:0])
            3'b001, 3'b010: operand = a_q;
            3'b011:         operand = a_q << 1;
            3'b100: begin
                operand = ~(a_q << 1);
                neg     = 1'b1;
            end
            3'b101, 3'b110: begin
                operand = ~a_q;
                neg     = 1'b1;
            end
            default: ;
        endcase
    end

    assign carry[0] = neg;

    for (genvar k = 0; k < NB; k++) begin : g_cs
        if (k < NB - 1) begin : g_mid
            logic [SIZE_CS:0] s0;
            logic [SIZE_CS:0] s1;
            assign s0 = {1'b0, acc_q[k*SIZE_CS +: SIZE_CS]} + {1'b0, operand[k*SIZE_CS +: SIZE_CS]};
            assign s1 = {1'b0, acc_q[k*SIZE_CS +: SIZE_CS]} + {1'b0, operand[k*SIZE_CS +: SIZE_CS]}
                        + (SIZE_CS + 1)'(1);
            assign sum[k*SIZE_CS +: SIZE_CS] = carry[k] ? s1[SIZE_CS-1:0] : s0[SIZE_CS-1:0];
            assign carry[k+1] = carry[k] ? s1[SIZE_CS] : s0[SIZE_CS];
        end else begin : g_last
            // The top block has no carry-out; the product is modulo 2^2N.
            logic [SIZE_CS-1:0] s0;
            logic [SIZE_CS-1:0] s1;
            assign s0 = acc_q[k*SIZE_CS +: SIZE_CS] + operand[k*SIZE_CS +: SIZE_CS];
            assign s1 = acc_q[k*SIZE_CS +: SIZE_CS] + operand[k*SIZE_CS +: SIZE_CS] + SIZE_CS'(1);
            assign sum[k*SIZE_CS +: SIZE_CS] = carry[k] ? s1 : s0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            i_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mul_if.in_valid) begin
                        a_q        <= {{N{mul_if.A[N-1]}}, mul_if.A};
                        b_q        <= {mul_if.B, 1'b0};
                        acc_q      <= '0;
                        i_q        <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    acc_q <= sum;
                    a_q   <= a_q << 2;
                    b_q   <= b_q >> 2;
                    i_q   <= i_q + CW'(1);
                    if (i_q == LAST) begin
                        p_q         <= sum;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (mul_if.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mul_if.in_ready  = in_ready_q;
    assign mul_if.out_valid = out_valid_q;
    assign mul_if.busy      = busy_q;
    assign mul_if.P         = p_q;
endmodule
